cpu_step_controller: RTL and testbench
======================================

# cpu_step_controller

Run/halt/single-step sequencer for the SAP CPU core. Replaces the free-running slow clock with a clock enable on the single 20 MHz PLL clock domain. Turns two raw push-buttons into either a continuous run at a fixed step rate or one instruction-clock step per press. Stops automatically when the CPU executes HLT, and exports run state and a step counter for the debug LEDs.

## Interface
- `DEBOUNCE_CYCLES`, 200_000: consecutive stable cycles required to accept a button level change (10 ms at 20 MHz); ≥1.
- `RUN_DIV`, 1_000_000: clocks per `cpu_en` pulse in RUN (20 Hz at 20 MHz); ≥1.
- `REPEAT_DELAY`, 10_000_000: step-hold time before auto-repeat starts; only used with `STEP_AUTOREPEAT_EN`.
- `clk`  in  1  system clock (PLL output); all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_run_stop`  in  1  raw run/stop button, active-high, asynchronous to `clk`.
- `btn_step`  in  1  raw single-step button, active-high, asynchronous.
- `cpu_halt`  in  1  CPU HLT flag, level, synchronous to `clk`.
- `cpu_en`  out  1  registered one-cycle clock-enable pulse to the CPU.
- `run_active`  out  1  high while in RUN.
- `cpu_halted`  out  1  high while in CPU_HALTED.
- `step_count`  out  8  number of `cpu_en` pulses issued, wraps 255→0.

## Operation
- Reset: all outputs 0, all counters and synchronizers 0, FSM in IDLE.
- Input path, per button:
  - Two-flop synchronizer.
  - Debounce counter clears whenever the synced value equals the stable value, and increments otherwise.
  - The stable value flips when the counter reaches `DEBOUNCE_CYCLES`, and the counter clears at the same time.
  - A stable 0→1 transition produces a one-cycle press event. Releases produce no event.
- FSM states:
  - **IDLE**
    - `cpu_halt`=1 → CPU_HALTED.
    - Else run press → RUN, with the rate counter cleared.
    - Else step press → STEP.
  - **STEP**: `cpu_en`=1 for exactly this cycle, then → IDLE. `cpu_halt` is not sampled in STEP.
  - **RUN**
    - `cpu_halt`=1 → CPU_HALTED; no `cpu_en` is issued in that cycle.
    - Else run press → IDLE, with the rate counter cleared.
    - Else the rate counter counts 0..`RUN_DIV`-1. On the cycle it equals `RUN_DIV`-1, `cpu_en`=1 and the counter wraps to 0.
    - Step presses are ignored.
  - **CPU_HALTED**: `cpu_en`=0 and all presses are ignored. `cpu_halt`=0 → IDLE.
- Priority within a cycle: `cpu_halt` > run press > step press. A simultaneous run and step press in IDLE enters RUN.
- `RUN_DIV`=1: `cpu_en` is high every cycle in RUN while `cpu_halt`=0.
- `step_count` increments on every cycle with `cpu_en`=1.
- `run_active` and `cpu_halted` are decoded from the state register, so they are glitch-free.

## Timing
- Step latency: raw `btn_step` rises and holds → press event after `DEBOUNCE_CYCLES`+2 clocks → `cpu_en` high on clock `DEBOUNCE_CYCLES`+3 after the raw edge.
- First RUN pulse: `cpu_en` asserts `RUN_DIV` clocks after entering RUN. Subsequent pulses are exactly `RUN_DIV` clocks apart.
- Stop latency:
  - Run press: the state leaves RUN on the next edge.
  - `cpu_halt`: the `cpu_en` pulse is suppressed in the same cycle that `cpu_halt`=1 is sampled.
- `rst_n` low mid-operation clears all outputs immediately (asynchronous). The first action after release requires a fresh debounced press.
- Bounces shorter than `DEBOUNCE_CYCLES` generate no event.

## Configuration
- `STEP_AUTOREPEAT_EN` defined:
  - In IDLE, if the step button's stable value stays 1 for `REPEAT_DELAY` clocks after its press event, the FSM enters STEP.
  - From then on, while the button is still held, it enters STEP every `RUN_DIV` clocks.
  - Release, `cpu_halt`=1, or a run press ends the repeat, with the usual priorities.
- `STEP_AUTOREPEAT_EN` undefined: holding the step button yields exactly one step, and the repeat counter is not synthesized.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `RUN_DIV`=8, `REPEAT_DELAY`=16.
1. Assert `rst_n`=0, then release it with no presses → all outputs 0 for 50 clocks, FSM in IDLE.
2. Drive `btn_step` high for 3 clocks, then low 5 clocks, then high 10 clocks → no pulse from the glitch. A single `cpu_en` pulse appears 7 clocks after the final rising edge, and `step_count`=1.
3. Run press → `run_active`=1, then `cpu_en` every 8 clocks with 5 pulses counted. A second run press → `run_active`=0, no further pulses, and a simultaneous step press is ignored.
4. In RUN, raise `cpu_halt` on a terminal-count cycle → no `cpu_en` that cycle, `cpu_halted`=1, and step/run presses are ignored. Drop `cpu_halt` → IDLE, `cpu_halted`=0.
5. Assert `rst_n`=0 mid-RUN between clock edges → `cpu_en`, `run_active` and `step_count` go to 0 without waiting for a clock edge.
6. With `STEP_AUTOREPEAT_EN`, hold step for 60 clocks → first pulse at 7 clocks, then pulses every 8 clocks starting 16 clocks after the press event. Without the macro → exactly 1 pulse.

Source files
------------

// File: rtl/cpu_step_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | cpu_step_controller: run/halt/single-step clock-enable sequencer for the    |
// | SAP core, optional step auto-repeat via STEP_AUTOREPEAT_EN. Rev 1.0         |
// +-----------------------------------------------------------------------------+
module cpu_step_controller #(
   parameter int DEBOUNCE_CYCLES = 200_000,
   parameter int RUN_DIV         = 1_000_000
`ifdef STEP_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 10_000_000
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_run_stop,
   input  logic       btn_step,
   input  logic       cpu_halt,
   output logic       cpu_en,
   output logic       run_active,
   output logic       cpu_halted,
   output logic [7:0] step_count
);

   localparam int c_btn_run  = 0;
   localparam int c_btn_step = 1;

   localparam int                  c_db_w    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [c_db_w-1:0]   c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_db_w-1:0]   c_db_one  = c_db_w'(1);

   localparam int                  c_rate_w    = $clog2(RUN_DIV + 1);
   localparam logic [c_rate_w-1:0] c_rate_last = c_rate_w'(RUN_DIV - 1);
   localparam logic [c_rate_w-1:0] c_rate_one  = c_rate_w'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STEP   = 2'd1,
      S_RUN    = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   logic [1:0] btn_raw;
   logic [1:0] sync1_q, sync1_d;
   logic [1:0] sync2_q, sync2_d;
   logic [1:0] stable_q, stable_d;
   logic [1:0] press_q, press_d;
   logic [c_db_w-1:0] db_cnt_q [2];
   logic [c_db_w-1:0] db_cnt_d [2];

   state_t              state_q, state_d;
   logic [c_rate_w-1:0] rate_q, rate_d;
   logic                cpu_en_q, cpu_en_d;
   logic [7:0]          step_count_q, step_count_d;
   logic                step_req;

   assign btn_raw = {btn_step, btn_run_stop};

   // The counter measures how long the synced level has disagreed with the
   // accepted level; reaching the limit accepts the new level.
   always_comb begin
      sync1_d  = btn_raw;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      for (int i = 0; i < 2; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (db_cnt_q[i] == c_db_last) begin
               stable_d[i] = ~stable_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + c_db_one;
            end
         end
      end
      press_d = stable_d & ~stable_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         stable_q    <= '0;
         press_q     <= '0;
         db_cnt_q[0] <= '0;
         db_cnt_q[1] <= '0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         stable_q    <= stable_d;
         press_q     <= press_d;
         db_cnt_q[0] <= db_cnt_d[0];
         db_cnt_q[1] <= db_cnt_d[1];
      end
   end

`ifdef STEP_AUTOREPEAT_EN
   localparam int c_rep_max = (REPEAT_DELAY > RUN_DIV) ? REPEAT_DELAY : RUN_DIV;
   localparam int c_rep_w   = $clog2(c_rep_max + 1);

   logic [c_rep_w-1:0] rep_q, rep_d, rep_last;
   logic               rep_on_q, rep_on_d;
   logic               rep_phase_q, rep_phase_d;
   logic               rep_fire;

   // Phase 0 waits out the initial hold delay, phase 1 repeats at the run rate.
   // The press cycle itself counts as cycle 0 of the hold delay.
   always_comb begin
      rep_last    = rep_phase_q ? c_rep_w'(RUN_DIV - 1) : c_rep_w'(REPEAT_DELAY - 1);
      rep_d       = rep_q;
      rep_on_d    = rep_on_q;
      rep_phase_d = rep_phase_q;
      rep_fire    = 1'b0;
      if (press_q[c_btn_step]) begin
         rep_d       = c_rep_w'(1);
         rep_on_d    = 1'b1;
         rep_phase_d = 1'b0;
      end else if (!stable_q[c_btn_step] || state_q == S_RUN || state_q == S_HALTED) begin
         rep_d       = '0;
         rep_on_d    = 1'b0;
         rep_phase_d = 1'b0;
      end else if (rep_on_q) begin
         if (rep_q == rep_last) begin
            rep_fire    = 1'b1;
            rep_d       = '0;
            rep_phase_d = 1'b1;
         end else begin
            rep_d = rep_q + c_rep_w'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_q       <= '0;
         rep_on_q    <= 1'b0;
         rep_phase_q <= 1'b0;
      end else begin
         rep_q       <= rep_d;
         rep_on_q    <= rep_on_d;
         rep_phase_q <= rep_phase_d;
      end
   end

   assign step_req = press_q[c_btn_step] | rep_fire;
`else
   assign step_req = press_q[c_btn_step];
`endif

   always_comb begin
      state_d  = state_q;
      rate_d   = rate_q;
      cpu_en_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cpu_halt) begin
               state_d = S_HALTED;
            end else if (press_q[c_btn_run]) begin
               state_d = S_RUN;
               rate_d  = '0;
            end else if (step_req) begin
               state_d  = S_STEP;
               cpu_en_d = 1'b1;
            end
         end
         S_STEP: begin
            state_d = S_IDLE;
         end
         S_RUN: begin
            if (cpu_halt) begin
               state_d = S_HALTED;
            end else if (press_q[c_btn_run]) begin
               state_d = S_IDLE;
               rate_d  = '0;
            end else if (rate_q == c_rate_last) begin
               cpu_en_d = 1'b1;
               rate_d   = '0;
            end else begin
               rate_d = rate_q + c_rate_one;
            end
         end
         S_HALTED: begin
            if (!cpu_halt) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      step_count_d = step_count_q + {7'd0, cpu_en_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         rate_q       <= '0;
         cpu_en_q     <= 1'b0;
         step_count_q <= '0;
      end else begin
         state_q      <= state_d;
         rate_q       <= rate_d;
         cpu_en_q     <= cpu_en_d;
         step_count_q <= step_count_d;
      end
   end

   assign cpu_en     = cpu_en_q;
   assign run_active = (state_q == S_RUN);
   assign cpu_halted = (state_q == S_HALTED);
   assign step_count = step_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_cpu_step_controller: directed self-checking bench for cpu_step_controller |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_cpu_step_controller;

   logic       clk          = 1'b0;
   logic       rst_n        = 1'b1;
   logic       btn_run_stop = 1'b0;
   logic       btn_step     = 1'b0;
   logic       cpu_halt     = 1'b0;
   logic       cpu_en;
   logic       run_active;
   logic       cpu_halted;
   logic [7:0] step_count;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int pulses  = 0;
   int last_pulse = -1;
   int ptimes[$];

   cpu_step_controller #(
      .DEBOUNCE_CYCLES(4),
      .RUN_DIV        (8)
`ifdef STEP_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (16)
`endif
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_run_stop(btn_run_stop),
      .btn_step    (btn_step),
      .cpu_halt    (cpu_halt),
      .cpu_en      (cpu_en),
      .run_active  (run_active),
      .cpu_halted  (cpu_halted),
      .step_count  (step_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (cpu_en) begin
         pulses++;
         last_pulse = cyc;
         ptimes.push_back(cyc);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic restart_window();
      cyc = 0;
      pulses = 0;
      last_pulse = -1;
      ptimes.delete();
   endtask

   initial begin
      int bad;
      int exp_rep[7];
      exp_rep = '{7, 22, 30, 38, 46, 54, 62};

      // Reset and quiet idle
      #2 rst_n = 1'b0;
      #20;
      check("rst_cpu_en", cpu_en, 0);
      check("rst_run_active", run_active, 0);
      check("rst_cpu_halted", cpu_halted, 0);
      check("rst_step_count", step_count, 0);
      @(negedge clk) rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (cpu_en || run_active || cpu_halted || step_count != 0) bad++;
      end
      check("idle_quiet_cycles", bad, 0);

      // Short glitch then a real step press
      restart_window();
      btn_step = 1'b1; ticks(3);
      btn_step = 1'b0; ticks(5);
      check("glitch_pulses", pulses, 0);
      restart_window();
      btn_step = 1'b1;
      ticks(6);
      check("step_t6_low", cpu_en, 0);
      tick();
      check("step_t7_pulse", cpu_en, 1);
      check("step_count_1", step_count, 1);
      tick();
      check("step_t8_low", cpu_en, 0);
      ticks(2);
      btn_step = 1'b0;
      ticks(12);
      check("step_single_pulse", pulses, 1);
      check("step_count_hold", step_count, 1);

      // Run at the fixed rate, then stop with a concurrent step press
      restart_window();
      btn_run_stop = 1'b1;
      ticks(6);
      check("run_t6_inactive", run_active, 0);
      tick();
      check("run_t7_active", run_active, 1);
      ticks(3);
      btn_run_stop = 1'b0;
      ticks(37);
      check("run_pulse_count", pulses, 5);
      check("run_last_pulse", last_pulse, 47);
      check("run_step_count", step_count, 6);
      restart_window();
      btn_run_stop = 1'b1;
      btn_step     = 1'b1;
      ticks(7);
      check("stop_run_active", run_active, 0);
      ticks(3);
      btn_run_stop = 1'b0;
      btn_step     = 1'b0;
      ticks(30);
      check("stop_no_pulses", pulses, 0);
      check("stop_step_count", step_count, 6);

      // Halt on a terminal-count cycle
      restart_window();
      btn_run_stop = 1'b1;
      ticks(7);
      check("halt_run_active", run_active, 1);
      ticks(3);
      btn_run_stop = 1'b0;
      ticks(5);
      check("halt_first_pulse", cpu_en, 1);
      ticks(7);
      cpu_halt = 1'b1;
      tick();
      check("halt_suppress", cpu_en, 0);
      check("halt_cpu_halted", cpu_halted, 1);
      check("halt_run_off", run_active, 0);
      check("halt_step_count", step_count, 7);
      restart_window();
      btn_step = 1'b1; btn_run_stop = 1'b1;
      ticks(10);
      btn_step = 1'b0; btn_run_stop = 1'b0;
      ticks(10);
      check("halt_presses_ignored", pulses, 0);
      check("halt_still_halted", cpu_halted, 1);
      check("halt_no_run", run_active, 0);
      cpu_halt = 1'b0;
      tick();
      check("unhalt_cpu_halted", cpu_halted, 0);
      check("unhalt_run_active", run_active, 0);
      ticks(10);
      check("unhalt_no_pulses", pulses, 0);

      // Asynchronous reset mid-run
      restart_window();
      btn_run_stop = 1'b1;
      ticks(10);
      btn_run_stop = 1'b0;
      ticks(5);
      check("pre_rst_pulse", cpu_en, 1);
      check("pre_rst_count", step_count, 8);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_cpu_en", cpu_en, 0);
      check("async_rst_run_active", run_active, 0);
      check("async_rst_step_count", step_count, 0);
      #10;
      @(negedge clk) rst_n = 1'b1;
      restart_window();
      ticks(20);
      check("post_rst_pulses", pulses, 0);
      check("post_rst_run_active", run_active, 0);

      // Held step button
      restart_window();
      btn_step = 1'b1;
      ticks(60);
      btn_step = 1'b0;
      ticks(20);
`ifdef STEP_AUTOREPEAT_EN
      check("hold_pulse_count", pulses, 7);
      for (int k = 0; k < 7; k++) begin
         check($sformatf("hold_pulse_%0d", k), (ptimes.size() > k) ? ptimes[k] : -1, exp_rep[k]);
      end
      check("hold_step_count", step_count, 7);
`else
      check("hold_pulse_count", pulses, 1);
      check("hold_pulse_time", (ptimes.size() > 0) ? ptimes[0] : -1, exp_rep[0]);
      check("hold_step_count", step_count, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
